pdm_stereo_capture: RTL and testbench

- Front end of the lesson_3 beamforming path; sits directly upstream of the delay-and-sum stages.
- Generates the PDM microphone clock from s_clk.
- Demultiplexes the shared stereo PDM data line into left and right samples.
- Maintains two WINDOW_SIZE-bit rolling buffers, which delay-sum instances index at fixed tap positions, plus a per-sample strobe and a fill indication.

---
 rtl/pdm_pkg.sv | 13 +
 rtl/pdm_clk_gen.sv | 47 ++++
 rtl/pdm_stereo_capture.sv | 101 ++++++++++
 tb/tb_pdm_stereo_capture.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared constants for the lesson_3 PDM capture and delay-and-sum path.
// WINDOW_SIZE must match the value delay_sum uses for its tap positions.
package pdm_pkg;

    localparam int PDM_WINDOW_SIZE = 64;
    localparam int PDM_CLK_DIV     = 32;
    localparam int PDM_SYNC_STAGES = 2;

    function automatic int fill_w(input int window_size);
        return $clog2(window_size + 1);
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM clock divider: a 50% duty pdm_clk plus strobes marking the last
// s_clk cycle of the high phase (left_tick) and of the low phase (right_tick).
module pdm_clk_gen import pdm_pkg::*; #(
    parameter int CLK_DIV = PDM_CLK_DIV
) (
    input  logic s_clk,
    input  logic n_rst,
    input  logic en,
    output logic pdm_clk,
    output logic left_tick,
    output logic right_tick
);

    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST      = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] HALF_CNT  = CW'(HALF);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          pdm_clk_q, pdm_clk_d;

    // pdm_clk is derived from the next count so it always equals (div_cnt < HALF).
    always_comb begin
        div_cnt_d = LAST;
        pdm_clk_d = 1'b0;
        if (en) begin
            div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
            pdm_clk_d = (div_cnt_d < HALF_CNT);
        end
    end

    always_ff @(posedge s_clk) begin
        if (!n_rst) begin
            div_cnt_q <= LAST;
            pdm_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pdm_clk_q <= pdm_clk_d;
        end
    end

    assign pdm_clk    = pdm_clk_q;
    assign left_tick  = en && (div_cnt_q == HALF_LAST);
    assign right_tick = en && (div_cnt_q == LAST);

endmodule

// File: rtl/pdm_stereo_capture.sv
// Stereo PDM front end: divides s_clk into pdm_clk, synchronises the shared
// data line and shifts left/right samples into rolling buffers (bit 0 newest).
module pdm_stereo_capture import pdm_pkg::*; #(
    parameter int WINDOW_SIZE = PDM_WINDOW_SIZE,
    parameter int CLK_DIV     = PDM_CLK_DIV,
    parameter int SYNC_STAGES = PDM_SYNC_STAGES
) (
    input  logic                             s_clk,
    input  logic                             n_rst,
    input  logic                             en,
    input  logic                             pdm_data,
    output logic                             pdm_clk,
    output logic [WINDOW_SIZE-1:0]           left_rolling_buffer,
    output logic [WINDOW_SIZE-1:0]           right_rolling_buffer,
    output logic                             sample_stb,
    output logic [fill_w(WINDOW_SIZE)-1:0]   fill_count,
    output logic                             buffers_valid
);

    localparam int FW = fill_w(WINDOW_SIZE);
    localparam logic [FW-1:0] FULL = FW'(WINDOW_SIZE);

    logic                   left_tick, right_tick;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pdm_sync;
    logic [WINDOW_SIZE-1:0] left_buf_q, left_buf_d;
    logic [WINDOW_SIZE-1:0] right_buf_q, right_buf_d;
    logic                   left_seen_q, left_seen_d;
    logic                   sample_stb_q, sample_stb_d;
    logic [FW-1:0]          fill_count_q, fill_count_d;
    logic                   buffers_valid_q, buffers_valid_d;

    pdm_clk_gen #(
        .CLK_DIV    (CLK_DIV)
    ) u_clk_gen (
        .s_clk      (s_clk),
        .n_rst      (n_rst),
        .en         (en),
        .pdm_clk    (pdm_clk),
        .left_tick  (left_tick),
        .right_tick (right_tick)
    );

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], pdm_data};
    assign pdm_sync = sync_q[SYNC_STAGES-1];

    // A right sample only commits a pair if a left sample preceded it.
    always_comb begin
        left_buf_d      = left_buf_q;
        right_buf_d     = right_buf_q;
        left_seen_d     = left_seen_q;
        sample_stb_d    = 1'b0;
        fill_count_d    = fill_count_q;
        buffers_valid_d = 1'b0;
        if (!en) begin
            left_buf_d   = '0;
            right_buf_d  = '0;
            left_seen_d  = 1'b0;
            fill_count_d = '0;
        end else begin
            if (left_tick) begin
                left_buf_d  = {left_buf_q[WINDOW_SIZE-2:0], pdm_sync};
                left_seen_d = 1'b1;
            end
            if (right_tick && left_seen_q) begin
                right_buf_d  = {right_buf_q[WINDOW_SIZE-2:0], pdm_sync};
                left_seen_d  = 1'b0;
                sample_stb_d = 1'b1;
                fill_count_d = (fill_count_q == FULL) ? FULL : fill_count_q + 1'b1;
            end
            buffers_valid_d = (fill_count_d == FULL);
        end
    end

    always_ff @(posedge s_clk) begin
        if (!n_rst) begin
            sync_q          <= '0;
            left_buf_q      <= '0;
            right_buf_q     <= '0;
            left_seen_q     <= 1'b0;
            sample_stb_q    <= 1'b0;
            fill_count_q    <= '0;
            buffers_valid_q <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            left_buf_q      <= left_buf_d;
            right_buf_q     <= right_buf_d;
            left_seen_q     <= left_seen_d;
            sample_stb_q    <= sample_stb_d;
            fill_count_q    <= fill_count_d;
            buffers_valid_q <= buffers_valid_d;
        end
    end

    assign left_rolling_buffer  = left_buf_q;
    assign right_rolling_buffer = right_buf_q;
    assign sample_stb           = sample_stb_q;
    assign fill_count           = fill_count_q;
    assign buffers_valid        = buffers_valid_q;

endmodule

// File: tb/tb_pdm_stereo_capture.sv
// Bench for pdm_stereo_capture: directed scenarios plus randomized traffic,
// all checked every cycle against a period-counting reference model.
module tb_pdm_stereo_capture;

    localparam int WS = 8;
    localparam int CD = 4;
    localparam int SS = 2;

    logic        s_clk;
    logic        n_rst;
    logic        en;
    logic        pdm_data;
    logic        pdm_clk;
    logic [7:0]  left_rolling_buffer;
    logic [7:0]  right_rolling_buffer;
    logic        sample_stb;
    logic [3:0]  fill_count;
    logic        buffers_valid;

    int total;
    int bad;

    // Reference model: counts enabled edges since enable/reset and places
    // samples by position within each 4-cycle pdm period.
    logic [7:0] m_left;
    logic [7:0] m_right;
    int         m_fill;
    int         m_k;
    bit         m_pend;
    bit         m_stb;
    bit         m_valid;
    bit         m_pclk;
    bit         h1;
    bit         h2;

    logic       pat [0:8];

    pdm_stereo_capture #(
        .WINDOW_SIZE          (WS),
        .CLK_DIV              (CD),
        .SYNC_STAGES          (SS)
    ) dut (
        .s_clk                (s_clk),
        .n_rst                (n_rst),
        .en                   (en),
        .pdm_data             (pdm_data),
        .pdm_clk              (pdm_clk),
        .left_rolling_buffer  (left_rolling_buffer),
        .right_rolling_buffer (right_rolling_buffer),
        .sample_stb           (sample_stb),
        .fill_count           (fill_count),
        .buffers_valid        (buffers_valid)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelClear();
        m_left  = '0;
        m_right = '0;
        m_fill  = 0;
        m_k     = 0;
        m_pend  = 1'b0;
        m_stb   = 1'b0;
        m_valid = 1'b0;
        m_pclk  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model by one edge, then compare.
    task automatic applyStimulus(input logic r, input logic e, input logic d);
        bit sampled;
        @(negedge s_clk);
        n_rst    = r;
        en       = e;
        pdm_data = d;
        @(posedge s_clk);
        if (!r) begin
            modelClear();
            h1 = 1'b0;
            h2 = 1'b0;
        end else begin
            sampled = h2;
            h2 = h1;
            h1 = d;
            if (!e) begin
                modelClear();
            end else begin
                m_k++;
                m_stb = 1'b0;
                if (m_k % 4 == 3) begin
                    m_left = {m_left[6:0], sampled};
                    m_pend = 1'b1;
                end
                if (m_k % 4 == 1 && m_pend) begin
                    m_right = {m_right[6:0], sampled};
                    m_pend  = 1'b0;
                    m_stb   = 1'b1;
                    if (m_fill < WS) m_fill++;
                end
                m_valid = (m_fill == WS);
                m_pclk  = ((m_k - 1) % 4) < 2;
            end
        end
        #1;
        checkOutput("pdm_clk", 32'(pdm_clk), 32'(m_pclk));
        checkOutput("left", 32'(left_rolling_buffer), 32'(m_left));
        checkOutput("right", 32'(right_rolling_buffer), 32'(m_right));
        checkOutput("stb", 32'(sample_stb), 32'(m_stb));
        checkOutput("fill", 32'(fill_count), 32'(m_fill));
        checkOutput("valid", 32'(buffers_valid), 32'(m_valid));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        n_rst    = 1'b0;
        en       = 1'b0;
        pdm_data = 1'b0;
        h1       = 1'b0;
        h2       = 1'b0;
        modelClear();
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst_left", 32'(left_rolling_buffer), 32'h0);
        checkOutput("rst_fill", 32'(fill_count), 32'h0);
        checkOutput("rst_valid", 32'(buffers_valid), 32'h0);
        checkOutput("rst_pdm_clk", 32'(pdm_clk), 32'h0);

        // High-phase ones, low-phase zeros for eight full periods.
        for (int k = 1; k <= 33; k++) begin
            applyStimulus(1'b1, 1'b1, logic'(((k - 1) % 4) < 2));
            if (k <= 4) begin
                checkOutput("clk_pattern", 32'(pdm_clk), 32'(k <= 2));
                checkOutput("early_stb", 32'(sample_stb), 32'h0);
            end
            if (k >= 5 && (k % 4) == 1)
                checkOutput("fill_ramp", 32'(fill_count), 32'((k - 1) / 4));
            if (k == 29)
                checkOutput("valid_before_8th", 32'(buffers_valid), 32'h0);
        end
        checkOutput("ones_left", 32'(left_rolling_buffer), 32'hFF);
        checkOutput("zeros_right", 32'(right_rolling_buffer), 32'h00);
        checkOutput("valid_on_8th", 32'(buffers_valid), 32'h1);

        // Left bit pattern, one bit per period, then a ninth bit.
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 37; k++) begin
            applyStimulus(1'b1, 1'b1, pat[(k <= 36) ? (k - 1) / 4 : 8]);
            if (k == 33) begin
                checkOutput("pattern_left", 32'(left_rolling_buffer), 32'hB2);
                checkOutput("pattern_fill", 32'(fill_count), 32'h8);
            end
        end
        checkOutput("ninth_left", 32'(left_rolling_buffer), 32'h65);
        checkOutput("ninth_fill_sat", 32'(fill_count), 32'h8);

        // Drop enable between a left tick and its right tick.
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("drop_stb", 32'(sample_stb), 32'h0);
        checkOutput("drop_left", 32'(left_rolling_buffer), 32'h0);
        checkOutput("drop_fill", 32'(fill_count), 32'h0);
        checkOutput("drop_pdm_clk", 32'(pdm_clk), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 1'b1, 1'(k % 2));
            checkOutput("reenable_stb", 32'(sample_stb), 32'(k == 5));
        end

        // Synchronous reset mid-capture at fill_count 5.
        for (int k = 1; k <= 16; k++) applyStimulus(1'b1, 1'b1, logic'($urandom_range(0, 1)));
        checkOutput("pre_rst_fill", 32'(fill_count), 32'h5);
        n_rst = 1'b0;
        #2;
        checkOutput("no_async_rst", 32'(fill_count), 32'h5);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("mid_rst_fill", 32'(fill_count), 32'h0);
        checkOutput("mid_rst_left", 32'(left_rolling_buffer), 32'h0);
        checkOutput("mid_rst_pdm_clk", 32'(pdm_clk), 32'h0);

        // Randomized traffic with occasional enable drops and resets.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(logic'($urandom_range(0, 99) >= 2),
                          logic'($urandom_range(0, 99) >= 4),
                          logic'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
